// File: rtl/addsub_flag_pipe_pkg.sv
// Shared definitions for the add/sub flag pipeline: mode-bit layout and the
// overflow-rule helper used by the result stage.
package addsub_flag_pipe_pkg;

  localparam int MODE_W      = 3;
  localparam int MODE_SUB    = 0;
  localparam int MODE_SIGNED = 1;
  localparam int MODE_SAT    = 2;

  typedef logic [MODE_W-1:0] mode_t;

  // Signed rule: carry into MSB differs from carry out. Unsigned: carry out
  // for add, missing carry (borrow) for sub.
  function automatic logic ovf_rule(input logic is_signed, input logic is_sub,
                                    input logic c_out, input logic c_msb);
    if (is_signed) return c_out ^ c_msb;
    return is_sub ? ~c_out : c_out;
  endfunction

endpackage

// File: rtl/addsub_core.sv
// Combinational WIDTH-bit adder: {c_out, sum} = a + b_eff + cin, plus the
// carry into the MSB for signed overflow detection.
module addsub_core #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b_eff,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             c_msb
);

  logic [WIDTH:0] full;

  assign full  = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
  assign sum   = full[WIDTH-1:0];
  assign c_out = full[WIDTH];
  assign c_msb = sum[WIDTH-1] ^ a[WIDTH-1] ^ b_eff[WIDTH-1];

endmodule

// File: rtl/addsub_flag_pipe.sv
// Two-stage valid/ready add/sub pipeline with carry/overflow/zero/negative
// flags, optional saturation and a sticky overflow flag.
module addsub_flag_pipe
  import addsub_flag_pipe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_signed,
  input  logic             in_sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             out_neg,
  input  logic             sticky_clr,
  output logic             sticky_ovf
);

  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] UMAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  mode_t            s1_mode_q, s1_mode_d;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_sum_q, out_sum_d;
  logic             out_carry_q, out_carry_d;
  logic             out_ovf_q, out_ovf_d;
  logic             out_zero_q, out_zero_d;
  logic             out_neg_q, out_neg_d;
  logic             sticky_q, sticky_d;

  logic             s2_load, s1_fire, in_fire, out_fire;
  logic [WIDTH-1:0] core_sum, res_sum;
  logic             core_c_out, core_c_msb, raw_ovf;

  assign s2_load  = !out_valid_q || out_ready;
  assign s1_fire  = s1_valid_q && s2_load;
  assign in_ready = !s1_valid_q || s2_load;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;

  addsub_core #(.WIDTH(WIDTH)) u_core (
    .a     (s1_a_q),
    .b_eff (s1_b_q),
    .cin   (s1_mode_q[MODE_SUB]),
    .sum   (core_sum),
    .c_out (core_c_out),
    .c_msb (core_c_msb)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_mode_d  = s1_mode_q;
    if (s1_fire) s1_valid_d = 1'b0;
    if (in_fire) begin
      s1_valid_d            = 1'b1;
      s1_a_d                = in_a;
      s1_b_d                = in_sub ? ~in_b : in_b;
      s1_mode_d[MODE_SUB]    = in_sub;
      s1_mode_d[MODE_SIGNED] = in_signed;
      s1_mode_d[MODE_SAT]    = in_sat;
    end
  end

  always_comb begin
    raw_ovf = ovf_rule(s1_mode_q[MODE_SIGNED], s1_mode_q[MODE_SUB], core_c_out, core_c_msb);
    res_sum = core_sum;
    // Signed clamp direction follows A's sign; unsigned follows the operation.
    if (s1_mode_q[MODE_SAT] && raw_ovf) begin
      if (s1_mode_q[MODE_SIGNED]) res_sum = s1_a_q[WIDTH-1] ? SMIN : SMAX;
      else                        res_sum = s1_mode_q[MODE_SUB] ? ZERO : UMAX;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_carry_d = out_carry_q;
    out_ovf_d   = out_ovf_q;
    out_zero_d  = out_zero_q;
    out_neg_d   = out_neg_q;
    if (s2_load) out_valid_d = s1_valid_q;
    if (s1_fire) begin
      out_sum_d   = res_sum;
      out_carry_d = core_c_out;
      out_ovf_d   = raw_ovf;
      out_zero_d  = (res_sum == ZERO);
      out_neg_d   = res_sum[WIDTH-1];
    end
    sticky_d = sticky_q;
    if (sticky_clr) sticky_d = 1'b0;
    if (out_fire && out_ovf_q) sticky_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= ZERO;
      s1_b_q      <= ZERO;
      s1_mode_q   <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= ZERO;
      out_carry_q <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_zero_q  <= 1'b0;
      out_neg_q   <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_mode_q   <= s1_mode_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_carry_q <= out_carry_d;
      out_ovf_q   <= out_ovf_d;
      out_zero_q  <= out_zero_d;
      out_neg_q   <= out_neg_d;
      sticky_q    <= sticky_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_sum    = out_sum_q;
  assign out_carry  = out_carry_q;
  assign out_ovf    = out_ovf_q;
  assign out_zero   = out_zero_q;
  assign out_neg    = out_neg_q;
  assign sticky_ovf = sticky_q;

endmodule

// File: tb/tb_addsub_flag_pipe.sv
// Bench for addsub_flag_pipe: directed corner beats, backpressure, sticky and
// reset scenarios plus randomized traffic against an arithmetic reference model.
module tb_addsub_flag_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, in_ready, in_sub, in_signed, in_sat;
  logic [31:0] in_a, in_b, out_sum;
  logic        out_valid, out_ready, out_carry, out_ovf, out_zero, out_neg;
  logic        sticky_clr, sticky_ovf;

  logic        in_valid8, in_ready8, out_valid8, out_carry8, out_ovf8, out_zero8, out_neg8, sticky_ovf8;
  logic [7:0]  in_a8, in_b8, out_sum8;

  addsub_flag_pipe #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_signed(in_signed), .in_sat(in_sat),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_carry(out_carry),
    .out_ovf(out_ovf), .out_zero(out_zero), .out_neg(out_neg),
    .sticky_clr(sticky_clr), .sticky_ovf(sticky_ovf)
  );

  addsub_flag_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_a(in_a8), .in_b(in_b8), .in_sub(1'b1), .in_signed(1'b1), .in_sat(1'b0),
    .out_valid(out_valid8), .out_ready(1'b1), .out_sum(out_sum8), .out_carry(out_carry8),
    .out_ovf(out_ovf8), .out_zero(out_zero8), .out_neg(out_neg8),
    .sticky_clr(1'b0), .sticky_ovf(sticky_ovf8)
  );

  typedef struct {
    logic [31:0] sum;
    logic        carry;
    logic        ovf;
    logic        zero;
    logic        neg;
    int          acc;
  } beat_t;

  beat_t       exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          outs = 0;
  logic        sticky_exp = 1'b0;
  logic        chk_lat = 1'b0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_sum, last_sum;
  logic [3:0]  prev_flags;
  logic        last_carry, last_ovf, last_zero, last_neg;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference computed with wide integer arithmetic, not carry bits.
  function automatic beat_t model(input logic [31:0] a, input logic [31:0] b,
                                  input logic sub, input logic sgn, input logic sat);
    beat_t  r;
    longint sa, sb, ua, ub, rs, ru;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    rs = sub ? sa - sb : sa + sb;
    ru = sub ? ua - ub : ua + ub;
    r.carry = sub ? (a >= b) : (ru >= 64'sd4294967296);
    r.ovf   = sgn ? (rs > 64'sd2147483647 || rs < -64'sd2147483648) : (sub ? (a < b) : r.carry);
    r.sum   = ru[31:0];
    if (sat && r.ovf) begin
      if (sgn) r.sum = (rs > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
      else     r.sum = sub ? 32'h0 : 32'hFFFF_FFFF;
    end
    r.zero = (r.sum == 32'h0);
    r.neg  = r.sum[31];
    r.acc  = 0;
    return r;
  endfunction

  task automatic tick(output bit acc);
    beat_t b;
    logic  nxt;
    acc = 1'b0;
    @(negedge clk);
    if (!rst_n) begin
      exp_q.delete();
      sticky_exp = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 64'(out_valid), 64'(1));
        chk("hold_sum", 64'(out_sum), 64'(prev_sum));
        chk("hold_flags", 64'({out_carry, out_ovf, out_zero, out_neg}), 64'(prev_flags));
      end
      chk("sticky", 64'(sticky_ovf), 64'(sticky_exp));
      if (in_valid && in_ready) begin
        acc = 1'b1;
        b = model(in_a, in_b, in_sub, in_signed, in_sat);
        b.acc = cyc;
        exp_q.push_back(b);
      end
      nxt = sticky_clr ? 1'b0 : sticky_exp;
      if (out_valid && out_ready) begin
        outs++;
        if (exp_q.size() == 0) begin
          chk("extra_beat", 64'(exp_q.size()), 64'(1));
        end else begin
          b = exp_q.pop_front();
          chk("sum", 64'(out_sum), 64'(b.sum));
          chk("carry", 64'(out_carry), 64'(b.carry));
          chk("ovf", 64'(out_ovf), 64'(b.ovf));
          chk("zero", 64'(out_zero), 64'(b.zero));
          chk("neg", 64'(out_neg), 64'(b.neg));
          if (chk_lat) chk("latency", 64'(cyc - b.acc), 64'(2));
          if (b.ovf) nxt = 1'b1;
        end
        last_sum = out_sum; last_carry = out_carry; last_ovf = out_ovf;
        last_zero = out_zero; last_neg = out_neg;
      end
      prev_stall = out_valid && !out_ready;
      prev_sum   = out_sum;
      prev_flags = {out_carry, out_ovf, out_zero, out_neg};
      sticky_exp = nxt;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic sub, input logic sgn, input logic sat);
    bit acc;
    acc = 1'b0;
    in_a = a; in_b = b; in_sub = sub; in_signed = sgn; in_sat = sat; in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick(acc);
      if (acc) break;
    end
    chk("accept_timeout", 64'(acc), 64'(1));
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    for (int k = 0; k < 30 && exp_q.size() > 0; k++) tick(acc);
    chk("drain_timeout", 64'(exp_q.size()), 64'(0));
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 3))
      0:       return 32'h7FFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'($urandom_range(0, 3));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit acc;
    int i, c, outs0;
    logic [31:0] ba[4], bb[4];

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0;
    in_signed = 1'b0; in_sat = 1'b0; out_ready = 1'b1; sticky_clr = 1'b0;
    in_valid8 = 1'b0; in_a8 = '0; in_b8 = '0;
    tick(acc); tick(acc);
    rst_n = 1'b1;

    // reset state
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_sum", 64'(out_sum), 64'(0));
    chk("rst_flags", 64'({out_carry, out_ovf, out_zero, out_neg}), 64'(0));
    chk("rst_sticky", 64'(sticky_ovf), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));

    // 8-bit instance: 80 - 01 signed
    chk("w8_in_ready", 64'(in_ready8), 64'(1));
    in_a8 = 8'h80; in_b8 = 8'h01; in_valid8 = 1'b1;
    tick(acc);
    in_valid8 = 1'b0;
    tick(acc);
    chk("w8_valid", 64'(out_valid8), 64'(1));
    chk("w8_sum", 64'(out_sum8), 64'(8'h7F));
    chk("w8_ovf", 64'(out_ovf8), 64'(1));

    chk_lat = 1'b1;
    send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1, 1'b0); drain();
    chk("t1_sum", 64'(last_sum), 64'(32'h8000_0000));
    chk("t1_flags", 64'({last_carry, last_ovf, last_neg}), 64'(3'b011));
    send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1, 1'b1); drain();
    chk("t1_sat_sum", 64'(last_sum), 64'(32'h7FFF_FFFF));
    chk("t1_sat_neg", 64'(last_neg), 64'(0));

    send(32'h0, 32'h1, 1'b1, 1'b0, 1'b0); drain();
    chk("t2_sum", 64'(last_sum), 64'(32'hFFFF_FFFF));
    chk("t2_carry_ovf", 64'({last_carry, last_ovf}), 64'(2'b01));
    send(32'h0, 32'h1, 1'b1, 1'b0, 1'b1); drain();
    chk("t2_sat_sum", 64'(last_sum), 64'(0));
    chk("t2_sat_zero", 64'(last_zero), 64'(1));

    send(32'h8000_0000, 32'h1, 1'b1, 1'b1, 1'b0); drain();
    chk("t3_sum", 64'(last_sum), 64'(32'h7FFF_FFFF));
    chk("t3_ovf", 64'(last_ovf), 64'(1));
    send(32'h8000_0000, 32'h1, 1'b1, 1'b1, 1'b1); drain();
    chk("t3_sat_sum", 64'(last_sum), 64'(32'h8000_0000));

    // backpressure: 4 back-to-back beats, consumer stalled 5 cycles
    chk_lat = 1'b0;
    for (int k = 0; k < 4; k++) begin ba[k] = $urandom; bb[k] = $urandom; end
    outs0 = outs;
    i = 0;
    for (c = 0; c < 40 && (i < 4 || exp_q.size() > 0); c++) begin
      out_ready = (c >= 5);
      in_valid = (i < 4);
      if (i < 4) begin
        in_a = ba[i]; in_b = bb[i]; in_sub = i[0]; in_signed = i[1]; in_sat = 1'b0;
      end
      tick(acc);
      if (acc) i++;
      if (c == 1) chk("bp_in_ready_low", 64'(in_ready), 64'(0));
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp_accepted", 64'(i), 64'(4));
    chk("bp_outputs", 64'(outs - outs0), 64'(4));
    chk("bp_drained", 64'(exp_q.size()), 64'(0));

    // sticky: set and clear in the same cycle, then clear alone
    sticky_clr = 1'b1;
    send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1, 1'b0); drain();
    chk("sticky_set_wins", 64'(sticky_ovf), 64'(1));
    tick(acc);
    chk("sticky_cleared", 64'(sticky_ovf), 64'(0));
    sticky_clr = 1'b0;
    out_ready = 1'b0;
    send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) tick(acc);
    chk("sticky_stall_valid", 64'(out_valid), 64'(1));
    chk("sticky_stall_clear", 64'(sticky_ovf), 64'(0));
    out_ready = 1'b1;
    tick(acc);
    chk("sticky_after_xfer", 64'(sticky_ovf), 64'(1));

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_a = rnd_op(); in_b = rnd_op();
      in_sub = 1'($urandom); in_signed = 1'($urandom); in_sat = 1'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      sticky_clr = ($urandom_range(0, 7) == 0);
      tick(acc);
    end
    in_valid = 1'b0; out_ready = 1'b1; sticky_clr = 1'b0;
    drain();

    // reset with both stages full
    out_ready = 1'b0;
    send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1, 1'b0);
    send(32'h5, 32'h7, 1'b0, 1'b0, 1'b0);
    chk("rst_mid_full", 64'(out_valid), 64'(1));
    rst_n = 1'b0;
    tick(acc);
    rst_n = 1'b1;
    chk("rst_mid_out_valid", 64'(out_valid), 64'(0));
    chk("rst_mid_sticky", 64'(sticky_ovf), 64'(0));
    chk("rst_mid_in_ready", 64'(in_ready), 64'(1));
    out_ready = 1'b1;
    outs0 = outs;
    for (int k = 0; k < 6; k++) tick(acc);
    chk("rst_no_stale", 64'(outs - outs0), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
